fifo_ctrl: RTL

- Second-generation synchronous FIFO for inter-stage buffering in the core, e.g. decode queue and store buffer.
- Adds arbitrary (non-power-of-2) depth, an occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds a selectable first-word-fall-through (FWFT) read mode, synchronous flush, and sticky overflow/underflow error flags.
- Single clock domain.

---
 rtl/fifo_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous single-clock FIFO with arbitrary depth, occupancy
// count, programmable almost-full/almost-empty thresholds, selectable
// standard (1-cycle registered) or first-word-fall-through read mode,
// synchronous flush and sticky overflow/underflow flags.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   flush        synchronous clear of contents and error flags
//   write        push request, data_in is the pushed word
//   read         pop request (acknowledge of the head word in FWFT mode)
//   data_out     popped word (standard) or current head word (FWFT)
//   data_valid   data_out holds valid popped/head data
//   empty/full   count == 0 / count == depth
//   almost_empty count <= almost_empty_level
//   almost_full  count >= almost_full_level
//   count        current occupancy, 0..depth
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
module fifo_ctrl #(
  parameter int width              = 8,
  parameter int depth              = 8,
  parameter int fwft               = 0,
  parameter int almost_full_level  = depth - 1,
  parameter int almost_empty_level = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         write,
  input  logic [width-1:0]             data_in,
  input  logic                         read,
  output logic [width-1:0]             data_out,
  output logic                         data_valid,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  if (width < 1) begin : g_bad_width
    $error("fifo_ctrl: width must be >= 1");
  end
  if (depth < 2) begin : g_bad_depth
    $error("fifo_ctrl: depth must be >= 2");
  end
  if (fwft != 0 && fwft != 1) begin : g_bad_fwft
    $error("fifo_ctrl: fwft must be 0 or 1");
  end
  if (almost_full_level < 1 || almost_full_level > depth) begin : g_bad_afl
    $error("fifo_ctrl: almost_full_level must be in 1..depth");
  end
  if (almost_empty_level < 0 || almost_empty_level > depth - 1) begin : g_bad_ael
    $error("fifo_ctrl: almost_empty_level must be in 0..depth-1");
  end

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             rd_ok;
  logic             wr_ok;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO still accepts a write when the same cycle pops a word.
  assign rd_ok = read & ~empty;
  assign wr_ok = write & (~full | rd_ok);

  // Status is a function of the count register alone.
  assign empty        = (count == '0);
  assign full         = (count == CW'(depth));
  assign almost_empty = (int'(count) <= almost_empty_level);
  assign almost_full  = (int'(count) >= almost_full_level);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      // Flush wins over this cycle's read/write; neither raises a flag.
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (write && !wr_ok) overflow  <= 1'b1;
      if (read  && !rd_ok) underflow <= 1'b1;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem[wr_ptr] <= data_in;
  end

  if (fwft != 0) begin : g_fwft
    // Head word is presented directly; zero while empty.
    assign data_out   = empty ? '0 : mem[rd_ptr];
    assign data_valid = ~empty;
  end else begin : g_std
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_out   <= '0;
        data_valid <= 1'b0;
      end else if (flush) begin
        data_out   <= '0;
        data_valid <= 1'b0;
      end else if (rd_ok) begin
        data_out   <= mem[rd_ptr];
        data_valid <= 1'b1;
      end else begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
